// File: rtl/mcl_axil_master_responder.sv
// rtl/mcl_axil_master_responder.sv - MCL request packet in, one AXI-lite master transaction, MCL response packet out
// Optional feature macro: MCL_AXIL_POSTED_WRITE_EN (silent posted writes, sticky wr_err_o).
module mcl_axil_master_responder #(
    parameter int          mcl_width_p       = 128,
    parameter logic [31:0] axil_base_addr_p  = 32'h0,
    parameter int          max_out_credits_p = 16,
    localparam int         axil_mosi_width_lp = 111,
    localparam int         axil_miso_width_lp = 41,
    localparam int         credit_width_lp    = $clog2(max_out_credits_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          mcl_v_i,
    input  logic [mcl_width_p-1:0]        mcl_data_i,
    output logic                          mcl_r_o,
    output logic                          mcl_v_o,
    output logic [mcl_width_p-1:0]        mcl_data_o,
    input  logic                          mcl_r_i,
    output logic [axil_mosi_width_lp-1:0] m_axil_bus_o,
    input  logic [axil_miso_width_lp-1:0] m_axil_bus_i,
    output logic [credit_width_lp-1:0]    credits_o,
`ifdef MCL_AXIL_POSTED_WRITE_EN
    output logic                          wr_err_o,
`endif
    input  logic                          credit_return_i
);
    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] credit_one_lp = credit_width_lp'(1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_RESP} state_e;

    state_e                     r_state;
    logic [31:0]                r_addr, r_axil_addr, r_wdata;
    logic                       r_op;
    logic [7:0]                 r_tag;
    logic                       r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                       r_mcl_r, r_mcl_v;
    logic [mcl_width_p-1:0]     r_mcl_data;
    logic [credit_width_lp-1:0] r_credits, w_credits_next;
    logic                       w_accept, w_resp_hs;
    logic                       w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic [1:0]                 w_bresp, w_rresp;
    logic [31:0]                w_rdata;
    logic                       w_unused;
`ifdef MCL_AXIL_POSTED_WRITE_EN
    logic                       r_wr_err;
    assign wr_err_o = r_wr_err;
`endif

    // Bus packing, MSB first: aw{addr,prot,valid} w{data,strb,valid} bready ar{addr,prot,valid} rready
    assign m_axil_bus_o = {r_axil_addr, 3'b000, r_awvalid, r_wdata, 4'hF, r_wvalid, r_bready,
                           r_axil_addr, 3'b000, r_arvalid, r_rready};
    assign {w_awready, w_wready, w_bresp, w_bvalid, w_arready, w_rdata, w_rresp, w_rvalid} = m_axil_bus_i;
    assign w_unused = &{1'b0, mcl_data_i[127:80], mcl_data_i[71:65]};

    assign w_accept   = mcl_v_i & r_mcl_r;
    assign w_resp_hs  = r_mcl_v & mcl_r_i;
    assign mcl_r_o    = r_mcl_r;
    assign mcl_v_o    = r_mcl_v;
    assign mcl_data_o = r_mcl_data;
    assign credits_o  = r_credits;

    always_comb begin
        w_credits_next = r_credits;
        if (w_resp_hs && !credit_return_i && r_credits != '0)
            w_credits_next = r_credits - credit_one_lp;
        else if (!w_resp_hs && credit_return_i && r_credits != credit_max_lp)
            w_credits_next = r_credits + credit_one_lp;
    end

    // mcl_r_o is registered from the next state, so it is already low in the cycle after accept
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_axil_addr <= '0;
            r_wdata     <= '0;
            r_op        <= 1'b0;
            r_tag       <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_mcl_r     <= 1'b0;
            r_mcl_v     <= 1'b0;
            r_mcl_data  <= '0;
            r_credits   <= credit_max_lp;
`ifdef MCL_AXIL_POSTED_WRITE_EN
            r_wr_err    <= 1'b0;
`endif
        end else begin
            r_credits <= w_credits_next;
            case (r_state)
                S_IDLE: begin
                    r_mcl_r <= (w_credits_next != '0);
                    if (w_accept) begin
                        r_mcl_r     <= 1'b0;
                        r_addr      <= mcl_data_i[63:32];
                        r_axil_addr <= mcl_data_i[63:32] + axil_base_addr_p;
                        r_wdata     <= mcl_data_i[31:0];
                        r_op        <= mcl_data_i[64];
                        r_tag       <= mcl_data_i[79:72];
                        if (mcl_data_i[64]) begin
                            r_state   <= S_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_A;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (w_awready) r_awvalid <= 1'b0;
                    if (w_wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || w_awready) && (!r_wvalid || w_wready)) begin
                        r_state  <= S_WR_B;
                        r_bready <= 1'b1;
                    end
                end
                S_WR_B: begin
                    if (w_bvalid) begin
                        r_bready <= 1'b0;
`ifdef MCL_AXIL_POSTED_WRITE_EN
                        r_state  <= S_IDLE;
                        r_mcl_r  <= (w_credits_next != '0);
                        if (w_bresp != 2'b00) r_wr_err <= 1'b1;
`else
                        r_state    <= S_RESP;
                        r_mcl_v    <= 1'b1;
                        r_mcl_data <= {46'b0, w_bresp, r_tag, 7'b0, r_op, r_addr, 32'h0};
`endif
                    end
                end
                S_RD_A: begin
                    if (w_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_D;
                    end
                end
                S_RD_D: begin
                    if (w_rvalid) begin
                        r_rready   <= 1'b0;
                        r_state    <= S_RESP;
                        r_mcl_v    <= 1'b1;
                        r_mcl_data <= {46'b0, w_rresp, r_tag, 7'b0, r_op, r_addr, w_rdata};
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_mcl_v <= 1'b0;
                        r_state <= S_IDLE;
                        r_mcl_r <= (w_credits_next != '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
